// File: rtl/spi_controller_if.sv
// spi_controller_if: request/response handshake plus SPI pins of spi_controller.
//   req_valid/req_ready/req_rw/req_addr/req_wdata : request side
//   done/rx_data                                  : completion pulse and read byte
//   SCLK/nCS/COPI (controller out), CIPO (in)     : SPI mode-0 bus
// slave  : the controller itself.
// master : the requester and the serial responder.
interface spi_controller_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       done;
  logic [7:0] rx_data;
  logic       SCLK;
  logic       nCS;
  logic       COPI;
  logic       CIPO;

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, CIPO,
    output req_ready, done, rx_data, SCLK, nCS, COPI
  );

  modport master (
    output req_valid, req_rw, req_addr, req_wdata, CIPO,
    input  req_ready, done, rx_data, SCLK, nCS, COPI
  );
endinterface

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 initiator for 16-bit register-access frames.
// Frame = {rw, addr[6:0], data[7:0]}, MSB first on COPI; CIPO shifted in
// on every SCLK rise, low byte exported on rx_data at done.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : spi_controller_if.slave (request handshake, done/rx_data, SPI pins)
// Parameters: CLK_DIV (SCLK half-period), CS_SETUP, CS_HOLD, CS_IDLE (clk cycles).
module spi_controller #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_controller_if.slave bus
);

  // One shared phase counter, wide enough for the longest phase.
  localparam int M_A  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int M_B  = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int MAXP = (M_A > M_B) ? M_A : M_B;
  localparam int CW   = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] IDLE_LAST  = CW'(CS_IDLE - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
  } frame_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    bit_cnt, bit_n;
  logic          sclk_q, sclk_n;
  logic          ncs_q, ncs_n;
  logic [15:0]   tx_sh, tx_n;
  logic [15:0]   rx_sh, rx_n;
  logic          done_q, done_n;
  logic [7:0]    rx_data_q, rx_data_n;
  frame_t        req_frame;

  assign req_frame = {bus.req_rw, bus.req_addr, bus.req_wdata};

  // COPI is the MSB of the transmit register: loading the frame presents
  // bit 15, each SCLK fall shifts the next bit up, and clearing the register
  // on GAP entry (or reset) returns COPI to 0.
  assign bus.COPI      = tx_sh[15];
  assign bus.SCLK      = sclk_q;
  assign bus.nCS       = ncs_q;
  assign bus.done      = done_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.req_ready = (state == IDLE);

  // Upper received byte is shifted through but never exported.
  logic unused_rx_msb;
  assign unused_rx_msb = rx_sh[15];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      sclk_q    <= 1'b0;
      ncs_q     <= 1'b1;
      tx_sh     <= '0;
      rx_sh     <= '0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_cnt   <= bit_n;
      sclk_q    <= sclk_n;
      ncs_q     <= ncs_n;
      tx_sh     <= tx_n;
      rx_sh     <= rx_n;
      done_q    <= done_n;
      rx_data_q <= rx_data_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    bit_n     = bit_cnt;
    sclk_n    = sclk_q;
    ncs_n     = ncs_q;
    tx_n      = tx_sh;
    rx_n      = rx_sh;
    done_n    = 1'b0;
    rx_data_n = rx_data_q;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (bus.req_valid) begin
          state_n = SETUP;
          tx_n    = req_frame;
          rx_n    = '0;
          bit_n   = '0;
          sclk_n  = 1'b0;
          ncs_n   = 1'b0;
        end
      end

      SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_n = SHIFT;
          cnt_n   = '0;
        end
      end

      // sclk_q doubles as the phase flag: 0 = low phase, 1 = high phase.
      SHIFT: begin
        if (cnt == DIV_LAST) begin
          cnt_n = '0;
          if (!sclk_q) begin
            sclk_n = 1'b1;
            rx_n   = {rx_sh[14:0], bus.CIPO};
          end else begin
            sclk_n = 1'b0;
            if (bit_cnt == 4'd15) begin
              state_n = HOLD;   // bit 0 stays on COPI through HOLD
            end else begin
              bit_n = bit_cnt + 4'd1;
              tx_n  = {tx_sh[14:0], 1'b0};
            end
          end
        end
      end

      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_n = GAP;
          cnt_n   = '0;
          ncs_n   = 1'b1;
          tx_n    = '0;
        end
      end

      GAP: begin
        if (cnt == IDLE_LAST) begin
          state_n   = IDLE;
          cnt_n     = '0;
          done_n    = 1'b1;
          rx_data_n = rx_sh[7:0];
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: self-checking bench for spi_controller.
// Two instances: default timing (CLK_DIV=4, CS_*=2) and the fastest legal
// timing (CLK_DIV=1, CS_*=1). A shared monitor/responder observes the
// selected instance, collects COPI on SCLK rises, drives CIPO on SCLK falls
// and measures nCS low/high run lengths; expectations come from the frame
// layout and the timing formulas.
module tb_spi_controller;

  localparam int D0 = 4, S0 = 2, H0 = 2, I0 = 2;
  localparam int D1 = 1, S1 = 1, H1 = 1, I1 = 1;
  localparam int LIMIT = 2000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_controller_if bus0();
  spi_controller_if bus1();

  spi_controller #(.CLK_DIV(D0), .CS_SETUP(S0), .CS_HOLD(H0), .CS_IDLE(I0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  spi_controller #(.CLK_DIV(D1), .CS_SETUP(S1), .CS_HOLD(H1), .CS_IDLE(I1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  // Stimulus, steered to the selected instance.
  logic       sel = 1'b0;
  logic       tb_valid = 1'b0, tb_rw = 1'b0, tb_cipo = 1'b0;
  logic [6:0] tb_addr = '0;
  logic [7:0] tb_wdata = '0;

  assign bus0.req_valid = tb_valid & ~sel;
  assign bus1.req_valid = tb_valid & sel;
  assign bus0.req_rw    = tb_rw;    assign bus1.req_rw    = tb_rw;
  assign bus0.req_addr  = tb_addr;  assign bus1.req_addr  = tb_addr;
  assign bus0.req_wdata = tb_wdata; assign bus1.req_wdata = tb_wdata;
  assign bus0.CIPO      = tb_cipo;  assign bus1.CIPO      = tb_cipo;

  logic       m_sclk, m_ncs, m_copi, m_done, m_ready;
  logic [7:0] m_rx;
  assign m_sclk  = sel ? bus1.SCLK      : bus0.SCLK;
  assign m_ncs   = sel ? bus1.nCS       : bus0.nCS;
  assign m_copi  = sel ? bus1.COPI      : bus0.COPI;
  assign m_done  = sel ? bus1.done      : bus0.done;
  assign m_ready = sel ? bus1.req_ready : bus0.req_ready;
  assign m_rx    = sel ? bus1.rx_data   : bus0.rx_data;

  int tests = 0, failed = 0;

  // Monitor + responder, evaluated on the falling clock edge.
  logic [15:0] resp_word = '0;
  logic [15:0] mon_word = '0;
  logic        prev_ncs = 1'b1, prev_sclk = 1'b0, prev_copi = 1'b0;
  int rises = 0, falls = 0, ncs_low = 0, hi_run = 0, gap_len = 0;
  int unstable = 0, frames = 0, done_cnt = 0;

  always @(negedge clk) begin
    if (prev_ncs && !m_ncs) begin
      gap_len  = hi_run;
      rises    = 0;
      falls    = 0;
      ncs_low  = 0;
      mon_word = '0;
      unstable = 0;
      frames++;
      tb_cipo  = resp_word[15];
    end
    if (!m_ncs) ncs_low++;
    hi_run = m_ncs ? hi_run + 1 : 0;
    if (!prev_sclk && m_sclk) begin
      rises++;
      mon_word = {mon_word[14:0], m_copi};
    end
    if (prev_sclk && !m_sclk) begin
      falls++;
      if (falls < 16) tb_cipo = resp_word[15 - falls];
    end
    if (prev_sclk && m_sclk && (m_copi !== prev_copi)) unstable++;
    if (m_done === 1'b1) done_cnt++;
    prev_ncs  = m_ncs;
    prev_sclk = m_sclk;
    prev_copi = m_copi;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ncs_low_exp(input logic s);
    return s ? (S1 + 32 * D1 + H1) : (S0 + 32 * D0 + H0);
  endfunction
  function automatic int period_exp(input logic s);
    return 1 + ncs_low_exp(s) + (s ? I1 : I0);
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Accept one request and run until done. poke >= 0 injects a stray
  // request (addr 0x7F) at that cycle of the frame; hold keeps req_valid up.
  int lat, rbad;
  task automatic run_frame(input logic rw, input logic [6:0] a, input logic [7:0] d,
                           input logic [15:0] resp, input logic hold, input int poke);
    resp_word = resp;
    tb_rw = rw; tb_addr = a; tb_wdata = d; tb_valid = 1'b1;
    step();
    lat = 1; rbad = 0;
    tb_valid = hold;
    while (m_done !== 1'b1 && lat < LIMIT) begin
      if (m_ready !== 1'b0) rbad++;
      if (lat == poke) begin
        tb_valid = 1'b1; tb_rw = 1'b0; tb_addr = 7'h7F; tb_wdata = 8'h00;
      end else begin
        tb_valid = hold;
      end
      step();
      lat++;
    end
  endtask

  task automatic check_frame(input string name, input logic [15:0] exp_word,
                             input logic [7:0] exp_rx);
    chk({name, "_copi"},     mon_word, exp_word);
    chk({name, "_rises"},    rises, 16);
    chk({name, "_ncs_low"},  ncs_low, ncs_low_exp(sel));
    chk({name, "_latency"},  lat, period_exp(sel));
    chk({name, "_ready_lo"}, rbad, 0);
    chk({name, "_rx"},       m_rx, exp_rx);
    chk({name, "_stable"},   unstable, 0);
  endtask

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] resp;
    logic [15:0] exp_word;
    logic [7:0]  exp_rx;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic        rw;
    logic [6:0]  a;
    logic [7:0]  d;
    logic [15:0] r;
    int          f0, dc0, b;

    vecs[0] = '{1'b1, 7'h04, 8'h80, 16'h1234, 16'h8480, 8'h34};
    vecs[1] = '{1'b1, 7'h7F, 8'hFF, 16'hFFFF, 16'hFFFF, 8'hFF};
    vecs[2] = '{1'b0, 7'h55, 8'hAA, 16'h5A3C, 16'h55AA, 8'h3C};
    vecs[3] = '{1'b1, 7'h01, 8'hFF, 16'h0000, 16'h81FF, 8'h00};
    vecs[4] = '{1'b0, 7'h00, 8'h00, 16'h00A5, 16'h0000, 8'hA5};

    // Reset state.
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_ncs", m_ncs, 1'b1);
    chk("rst_sclk", m_sclk, 1'b0);
    chk("rst_copi", m_copi, 1'b0);
    chk("rst_done", m_done, 1'b0);
    chk("rst_rx", m_rx, 8'h00);
    rst_n = 1'b1;
    step();
    chk("rst_ready", m_ready, 1'b1);

    // Table vectors.
    foreach (vecs[i]) begin
      step();
      run_frame(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].resp, 1'b0, -1);
      check_frame($sformatf("vec%0d", i), vecs[i].exp_word, vecs[i].exp_rx);
    end
    repeat (10) step();
    chk("rx_hold", m_rx, 8'hA5);
    chk("idle_ncs", m_ncs, 1'b1);

    // Back-to-back with req_valid held: second accept in the done cycle.
    run_frame(1'b1, 7'h01, 8'hFF, 16'h1111, 1'b1, -1);
    check_frame("b2b_a", 16'h81FF, 8'h11);
    run_frame(1'b1, 7'h02, 8'h0F, 16'h2222, 1'b0, -1);
    check_frame("b2b_b", 16'h820F, 8'h22);
    chk("b2b_gap", gap_len, 1 + I0);

    // Stray request mid-frame is ignored.
    step();
    run_frame(1'b1, 7'h10, 8'h3C, 16'h00C3, 1'b0, 40);
    check_frame("ignore", 16'h903C, 8'hC3);
    f0 = frames; dc0 = done_cnt;
    repeat (20) step();
    chk("ignore_frames", frames, f0);
    chk("ignore_done", done_cnt, dc0);

    // Reset in the cycle after the 8th SCLK rise.
    resp_word = 16'hFFFF;
    tb_rw = 1'b1; tb_addr = 7'h33; tb_wdata = 8'h44; tb_valid = 1'b1;
    step();
    tb_valid = 1'b0;
    b = 0;
    while (rises < 8 && b < LIMIT) begin step(); b++; end
    chk("midrst_wait", rises, 8);
    dc0 = done_cnt;
    rst_n = 1'b0;
    step();
    chk("midrst_ncs", m_ncs, 1'b1);
    chk("midrst_sclk", m_sclk, 1'b0);
    chk("midrst_copi", m_copi, 1'b0);
    chk("midrst_done", m_done, 1'b0);
    chk("midrst_rx", m_rx, 8'h00);
    rst_n = 1'b1;
    step();
    chk("midrst_ready", m_ready, 1'b1);
    repeat (10) step();
    chk("midrst_no_done", done_cnt, dc0);
    run_frame(1'b0, 7'h21, 8'h5A, 16'hBEEF, 1'b0, -1);
    check_frame("midrst_after", 16'h215A, 8'hEF);

    // Randomized frames against the frame-layout model, both instances.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      repeat (3) step();
      for (int i = 0; i < (s == 0 ? 16 : 10); i++) begin
        rw = 1'($urandom);
        a  = 7'($urandom);
        d  = 8'($urandom);
        r  = 16'($urandom);
        repeat ($urandom_range(0, 3)) step();
        run_frame(rw, a, d, r, 1'b0, -1);
        check_frame($sformatf("rnd%0d_%0d", s, i), {rw, a, d}, r[7:0]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
